// File: rtl/rhs2116_emu_pkg.sv
// Shared opcodes, FSM state type and fixed response words for the RHS2116 SPI responder.
`timescale 1ns/1ps

package rhs2116_emu_pkg;

    localparam logic [1:0] OP_CONVERT = 2'b00;
    localparam logic [1:0] OP_RSVD    = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    typedef enum logic {
        IDLE,
        SHIFT
    } spi_state_t;

    localparam logic [31:0] RESP_RSVD = 32'hDEAD0000;
    localparam logic [15:0] WR_ACK_HI = 16'hFFFF;

    // CONVERT answers with the channel nibble from the command above the running sample count.
    function automatic logic [31:0] convert_resp(input logic [3:0] chan, input logic [27:0] cnt);
        return {chan, cnt};
    endfunction

endpackage

// File: rtl/rhs2116_spi_responder_pin_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, with rise/fall pulses taken against a third stage.
`timescale 1ns/1ps

module spi_pin_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sync_q <= {3{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[1:0], pin};
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/rhs2116_spi_responder.sv
// SPI mode-1 slave emulating the RHS2116 sensor: 32-bit frames, one-frame-delayed responses.
// Optional macro RHS_EMU_ERRINJ_EN adds err_inject, which flips bit 0 of the next loaded response.
`timescale 1ns/1ps

module rhs2116_spi_responder
    import rhs2116_emu_pkg::*;
#(
    parameter int          FRAME_BITS = 32,
    parameter int          NUM_REGS   = 8,
    parameter logic [27:0] CNT_INIT   = 28'h0000000
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic [31:0] cmd_data,
    output logic        cmd_valid,
    output logic        frame_abort,
    output logic [15:0] frame_cnt
`ifdef RHS_EMU_ERRINJ_EN
    ,
    input  logic        err_inject
`endif
);

    localparam int         AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [5:0] FULL_BITS = 6'(FRAME_BITS);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    spi_pin_sync #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk_sys (clk_sys),
        .rst     (rst),
        .pin     (cs_n),
        .level   (cs_level),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    spi_pin_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk_sys (clk_sys),
        .rst     (rst),
        .pin     (sclk),
        .level   (sclk_level),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    spi_pin_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk_sys (clk_sys),
        .rst     (rst),
        .pin     (mosi),
        .level   (mosi_level),
        .rise    (mosi_rise),
        .fall    (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, cs_level, sclk_level, mosi_rise, mosi_fall};

    spi_state_t state, next_state;

    logic                      load_tx, shift_tx, shift_rx, exec_cmd, abort_cmd;
    logic [31:0]               tx_sreg, rx_sreg, pending_resp, new_resp, load_word;
    logic [5:0]                bit_cnt;
    logic [27:0]               sample_cnt;
    logic [NUM_REGS-1:0][15:0] reg_file;

    logic [1:0]    opcode;
    logic [7:0]    addr;
    logic [15:0]   wdata;
    logic          addr_ok;
    logic [AW-1:0] reg_idx;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cs_fall) next_state = SHIFT;
            SHIFT:   if (cs_rise) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A cs_n rise takes priority over any SCLK edge seen in the same cycle.
    always_comb begin
        load_tx   = 1'b0;
        shift_tx  = 1'b0;
        shift_rx  = 1'b0;
        exec_cmd  = 1'b0;
        abort_cmd = 1'b0;
        case (state)
            IDLE: begin
                load_tx = cs_fall;
            end
            SHIFT: begin
                if (cs_rise) begin
                    exec_cmd  = (bit_cnt == FULL_BITS);
                    abort_cmd = (bit_cnt != FULL_BITS);
                end else begin
                    shift_tx = sclk_rise;
                    shift_rx = sclk_fall;
                end
            end
            default: ;
        endcase
    end

    assign opcode  = rx_sreg[31:30];
    assign addr    = rx_sreg[23:16];
    assign wdata   = rx_sreg[15:0];
    assign addr_ok = ({24'd0, addr} < 32'(NUM_REGS));
    assign reg_idx = addr[AW-1:0];

    always_comb begin
        new_resp = RESP_RSVD;
        case (opcode)
            OP_CONVERT: new_resp = convert_resp(rx_sreg[19:16], sample_cnt);
            OP_WRITE:   new_resp = {WR_ACK_HI, wdata};
            OP_READ:    new_resp = addr_ok ? {16'h0000, reg_file[reg_idx]} : 32'h00000000;
            OP_RSVD:    new_resp = RESP_RSVD;
            default:    new_resp = RESP_RSVD;
        endcase
    end

`ifdef RHS_EMU_ERRINJ_EN
    logic err_armed;

    // A pulse coinciding with a load arms the flag for the following load.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            err_armed <= 1'b0;
        end else if (load_tx) begin
            err_armed <= err_inject;
        end else if (err_inject) begin
            err_armed <= 1'b1;
        end
    end

    assign load_word = pending_resp ^ {31'd0, err_armed};
`else
    assign load_word = pending_resp;
`endif

    // Executions happen in SHIFT and loads in IDLE, so a load always sees an already updated pending_resp.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            tx_sreg <= '0;
            rx_sreg <= '0;
            bit_cnt <= '0;
            miso    <= 1'b0;
        end else begin
            if (load_tx) begin
                tx_sreg <= load_word;
                bit_cnt <= '0;
                miso    <= 1'b0;
            end
            if (shift_tx) begin
                miso    <= tx_sreg[31];
                tx_sreg <= {tx_sreg[30:0], 1'b0};
            end
            if (shift_rx) begin
                rx_sreg <= {rx_sreg[30:0], mosi_level};
                if (bit_cnt != FULL_BITS) begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
            end
            if (exec_cmd || abort_cmd) begin
                miso <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            cmd_data    <= '0;
            cmd_valid   <= 1'b0;
            frame_abort <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            cmd_valid   <= exec_cmd;
            frame_abort <= abort_cmd;
            if (exec_cmd) begin
                cmd_data  <= rx_sreg;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            pending_resp <= '0;
            sample_cnt   <= CNT_INIT;
            reg_file     <= '0;
        end else if (exec_cmd) begin
            pending_resp <= new_resp;
            if (opcode == OP_CONVERT) begin
                sample_cnt <= sample_cnt + 28'd1;
            end
            if (opcode == OP_WRITE && addr_ok) begin
                reg_file[reg_idx] <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_rhs2116_spi_responder.sv
// Scoreboard bench for rhs2116_spi_responder: SPI mode-1 master, reference model, decoupled monitors.
`timescale 1ns/1ps

module tb_rhs2116_spi_responder;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        frame_abort;
    logic [15:0] frame_cnt;
`ifdef RHS_EMU_ERRINJ_EN
    logic        err_inject;
`endif

    always #5 clk_sys = ~clk_sys;

    rhs2116_spi_responder dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .cs_n        (cs_n),
        .sclk        (sclk),
        .mosi        (mosi),
        .miso        (miso),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .frame_abort (frame_abort),
        .frame_cnt   (frame_cnt)
`ifdef RHS_EMU_ERRINJ_EN
        ,
        .err_inject  (err_inject)
`endif
    );

    typedef struct packed {
        logic [31:0] cmd;
        logic [15:0] cnt;
    } cmd_exp_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_miso_q[$];
    cmd_exp_t    exp_cmd_q[$];
    int          exp_aborts = 0;
    int          seen_aborts = 0;

    // Reference model of the sensor, kept at the level of the command rules.
    logic [31:0] m_pending;
    logic [27:0] m_cnt;
    logic [15:0] m_regs [8];
    logic [15:0] m_frames;
    bit          m_err_armed;

    bit          in_frame = 1'b0;
    logic [31:0] cap;
    int          ncap;
    logic [31:0] last_word;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic model_reset();
        m_pending   = 32'h0;
        m_cnt       = 28'h0;
        m_frames    = 16'h0;
        m_err_armed = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    endtask

    task automatic model_execute(input logic [31:0] cmd);
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [15:0] data;
        cmd_exp_t    e;
        op   = cmd[31:30];
        addr = cmd[23:16];
        data = cmd[15:0];
        if (op == 2'd0) begin
            m_pending = {cmd[19:16], m_cnt};
            m_cnt     = m_cnt + 28'd1;
        end else if (op == 2'd2) begin
            if (addr < 8) m_regs[addr[2:0]] = data;
            m_pending = {16'hFFFF, data};
        end else if (op == 2'd3) begin
            m_pending = (addr < 8) ? {16'h0000, m_regs[addr[2:0]]} : 32'h0;
        end else begin
            m_pending = 32'hDEAD0000;
        end
        m_frames = m_frames + 16'd1;
        e.cmd = cmd;
        e.cnt = m_frames;
        exp_cmd_q.push_back(e);
    endtask

    // Drives one frame of nbits SCLK periods (12.5 MHz) and records what the model expects of it.
    task automatic apply_stimulus(input logic [31:0] cmd, input int nbits);
        logic [31:0] exp_word;
        exp_word = m_pending;
        if (m_err_armed) begin
            exp_word[0] = ~exp_word[0];
            m_err_armed = 1'b0;
        end
        exp_miso_q.push_back(exp_word);
        if (nbits == 32) model_execute(cmd);
        else exp_aborts++;

        @(negedge clk_sys);
        cs_n = 1'b0;
        wait_cycles(4);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            mosi = cmd[31-i];
            wait_cycles(4);
            sclk = 1'b0;
            wait_cycles(4);
        end
        cs_n = 1'b1;
        wait_cycles(6);
    endtask

    // MISO monitor: assembles bits on master sampling edges, compares when the frame closes.
    always @(negedge cs_n) begin
        cap      = 32'h0;
        ncap     = 0;
        in_frame = 1'b1;
    end

    always @(negedge sclk) begin
        if (in_frame && !cs_n) begin
            cap  = {cap[30:0], miso};
            ncap = ncap + 1;
        end
    end

    always @(posedge cs_n) begin
        if (in_frame) begin
            logic [31:0] exp_word;
            in_frame  = 1'b0;
            last_word = cap;
            if (exp_miso_q.size() == 0) begin
                check_output("miso_unexpected_frame", cap, 32'hxxxxxxxx);
            end else begin
                exp_word = exp_miso_q.pop_front();
                if (ncap > 0) check_output("miso_word", cap, exp_word >> (32 - ncap));
            end
        end
    end

    // Command monitor: every cmd_valid must match the oldest expected full frame.
    always @(negedge clk_sys) begin
        if (rst === 1'b0) begin
            if (cmd_valid) begin
                if (exp_cmd_q.size() == 0) begin
                    check_output("cmd_valid_unexpected", cmd_data, 32'hxxxxxxxx);
                end else begin
                    cmd_exp_t e;
                    e = exp_cmd_q.pop_front();
                    check_output("cmd_data", cmd_data, e.cmd);
                    check_output("frame_cnt_at_valid", 32'(frame_cnt), 32'(e.cnt));
                end
            end
            if (frame_abort) seen_aborts++;
        end
    end

    initial begin
        logic [31:0] saved;
        rst  = 1'b1;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
`ifdef RHS_EMU_ERRINJ_EN
        err_inject = 1'b0;
`endif
        model_reset();
        wait_cycles(5);
        check_output("reset_miso", 32'(miso), 32'h0);
        check_output("reset_cmd_data", cmd_data, 32'h0);
        check_output("reset_cmd_valid", 32'(cmd_valid), 32'h0);
        check_output("reset_frame_abort", 32'(frame_abort), 32'h0);
        check_output("reset_frame_cnt", 32'(frame_cnt), 32'h0);
        rst = 1'b0;
        wait_cycles(3);

        $display("[TB] three CONVERT frames");
        apply_stimulus(32'h00030000, 32);
        check_output("convert_frame1", last_word, 32'h00000000);
        apply_stimulus(32'h00030000, 32);
        check_output("convert_frame2", last_word, 32'h30000000);
        apply_stimulus(32'h00030000, 32);
        check_output("convert_frame3", last_word, 32'h30000001);
        check_output("frame_cnt_after_3", 32'(frame_cnt), 32'd3);

        $display("[TB] write / read / convert");
        apply_stimulus(32'h8002ABCD, 32);
        apply_stimulus(32'hC0020000, 32);
        check_output("write_ack", last_word, 32'hFFFFABCD);
        apply_stimulus(32'h00030000, 32);
        check_output("read_back", last_word, 32'h0000ABCD);

        $display("[TB] out-of-range address");
        apply_stimulus(32'hC0090000, 32);
        apply_stimulus(32'h80091234, 32);
        check_output("read_addr9", last_word, 32'h00000000);
        apply_stimulus(32'hC0020000, 32);
        check_output("write_addr9_ack", last_word, 32'hFFFF1234);
        apply_stimulus(32'h00000000, 32);
        check_output("reg2_untouched", last_word, 32'h0000ABCD);

        $display("[TB] aborted frame");
        saved = m_pending;
        apply_stimulus(32'h80015555, 17);
        check_output("frame_cnt_after_abort", 32'(frame_cnt), 32'(m_frames));
        apply_stimulus(32'hC0010000, 32);
        check_output("pending_kept_after_abort", last_word, saved);

        $display("[TB] reset mid-frame");
        exp_miso_q.push_back(m_pending);
        @(negedge clk_sys);
        cs_n = 1'b0;
        wait_cycles(4);
        for (int i = 0; i < 10; i++) begin
            sclk = 1'b1;
            mosi = i[0];
            wait_cycles(4);
            sclk = 1'b0;
            wait_cycles(4);
        end
        rst = 1'b1;
        wait_cycles(2);
        cs_n = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        model_reset();
        wait_cycles(3);
        check_output("midreset_miso", 32'(miso), 32'h0);
        check_output("midreset_frame_cnt", 32'(frame_cnt), 32'h0);
        apply_stimulus(32'h00030000, 32);
        check_output("first_after_midreset", last_word, 32'h00000000);

`ifdef RHS_EMU_ERRINJ_EN
        $display("[TB] error injection");
        apply_stimulus(32'h00030000, 32);
        check_output("errinj_pre", last_word, 32'h30000000);
        err_inject = 1'b1;
        wait_cycles(1);
        err_inject = 1'b0;
        wait_cycles(2);
        err_inject = 1'b1;
        wait_cycles(1);
        err_inject = 1'b0;
        m_err_armed = 1'b1;
        apply_stimulus(32'h00030000, 32);
        check_output("errinj_flipped", last_word, 32'h30000000);
        apply_stimulus(32'h00030000, 32);
        check_output("errinj_cleared", last_word, 32'h30000002);
`endif

        $display("[TB] randomized frames");
        for (int n = 0; n < 100; n++) begin
            logic [31:0] c;
            int          nb;
            c        = $urandom;
            c[23:16] = 8'($urandom_range(0, 11));
            nb       = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 31)) : 32;
            apply_stimulus(c, nb);
        end
        for (int a = 0; a < 12; a++) begin
            logic [31:0] c;
            c        = 32'hC0000000;
            c[23:16] = 8'(a);
            apply_stimulus(c, 32);
        end
        apply_stimulus(32'h00000000, 32);

        wait_cycles(20);
        check_output("miso_queue_drained", 32'(exp_miso_q.size()), 32'h0);
        check_output("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'h0);
        check_output("abort_count", 32'(seen_aborts), 32'(exp_aborts));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
